// File: rtl/decode_pipeline.sv
// rtl/decode_pipeline.sv - RV32I decode stage: register file, immediate generator, main/ALU decoder, ID/EX register
//
// Purpose: decodes Instr_D from fetch and presents a registered ID/EX bundle one
// cycle later. Holds the 32x32 register file written back from the W stage.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-low reset
//   Instr_D, PC_D, PCPlusD  fetch-stage instruction and PC values
//   RegWriteW, RDW, ResultW write-back port into the register file
//   FlushE                 turns the next ID/EX load into a bubble
//   *E / *_E outputs       registered ID/EX bundle for the execute stage

module decode_pipeline #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     Instr_D,
    input  logic [XLEN-1:0] PC_D,
    input  logic [XLEN-1:0] PCPlusD,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] ImmExt_E,
    output logic [XLEN-1:0] PC_E,
    output logic [XLEN-1:0] PCPlusE,
    output logic [4:0]      RS1_E,
    output logic [4:0]      RS2_E,
    output logic [4:0]      RD_E,
    output logic            IllegalE
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ---------------------------------------------------------------- fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic [4:0] rs1, rs2, rd;

    assign opcode    = Instr_D[6:0];
    assign funct3    = Instr_D[14:12];
    assign funct7_b5 = Instr_D[30];
    assign rs1       = Instr_D[19:15];
    assign rs2       = Instr_D[24:20];
    assign rd        = Instr_D[11:7];

    // ---------------------------------------------------------- register file
    // x0 has no storage; reads of index 0 are forced to zero below.
    logic [XLEN-1:0] regs_q [1:NREGS-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (RegWriteW && RDW != 5'd0) begin
            regs_q[RDW] <= ResultW;
        end
    end

    // Write-first bypass: a W-stage write to the register being read this
    // cycle is visible immediately, so decode never sees a stale value.
    logic [XLEN-1:0] rd1_d, rd2_d;

    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (rs1 != 5'd0) begin
            if (RegWriteW && RDW == rs1) rd1_d = ResultW;
            else                         rd1_d = regs_q[rs1];
        end
        if (rs2 != 5'd0) begin
            if (RegWriteW && RDW == rs2) rd2_d = ResultW;
            else                         rd2_d = regs_q[rs2];
        end
    end

    // ------------------------------------------------------------- decoder
    logic            reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
    logic [1:0]      result_src_d;
    logic [2:0]      alu_control_d;
    logic [XLEN-1:0] imm_d;
    logic            illegal_d;

    // ALU op for R-type and I-ALU; sub only exists as an R-type encoding,
    // since bit 30 is part of the immediate for I-ALU.
    logic [2:0] alu_op;
    logic       alu_op_ok;

    always_comb begin
        alu_op    = ALU_ADD;
        alu_op_ok = 1'b1;
        unique case (funct3)
            3'b000:  alu_op = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op_ok = 1'b0;
        endcase
    end

    always_comb begin
        reg_write_d   = 1'b0;
        mem_write_d   = 1'b0;
        jump_d        = 1'b0;
        branch_d      = 1'b0;
        alu_src_d     = 1'b0;
        result_src_d  = 2'b00;
        alu_control_d = ALU_ADD;
        imm_d         = '0;
        illegal_d     = 1'b0;

        // An all-zero word is the fetch-side bubble: decode it as a NOP.
        if (Instr_D != 32'd0) begin
            unique case (opcode)
                OP_LW: begin
                    imm_d = {{20{Instr_D[31]}}, Instr_D[31:20]};
                    if (funct3 == 3'b010) begin
                        reg_write_d  = 1'b1;
                        alu_src_d    = 1'b1;
                        result_src_d = 2'b01;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                OP_SW: begin
                    imm_d = {{20{Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
                    if (funct3 == 3'b010) begin
                        mem_write_d = 1'b1;
                        alu_src_d   = 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                OP_R: begin
                    if (alu_op_ok) begin
                        reg_write_d   = 1'b1;
                        alu_control_d = alu_op;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                OP_I: begin
                    imm_d = {{20{Instr_D[31]}}, Instr_D[31:20]};
                    if (alu_op_ok) begin
                        reg_write_d   = 1'b1;
                        alu_src_d     = 1'b1;
                        alu_control_d = alu_op;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                OP_BEQ: begin
                    imm_d = {{19{Instr_D[31]}}, Instr_D[31], Instr_D[7],
                             Instr_D[30:25], Instr_D[11:8], 1'b0};
                    if (funct3 == 3'b000) begin
                        branch_d      = 1'b1;
                        alu_control_d = ALU_SUB;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                OP_JAL: begin
                    imm_d        = {{11{Instr_D[31]}}, Instr_D[31], Instr_D[19:12],
                                    Instr_D[20], Instr_D[30:21], 1'b0};
                    reg_write_d  = 1'b1;
                    jump_d       = 1'b1;
                    result_src_d = 2'b10;
                end
                default: illegal_d = 1'b1;
            endcase
        end
    end

    // ---------------------------------------------------------- ID/EX register
    logic            reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q;
    logic [1:0]      result_src_q;
    logic [2:0]      alu_control_q;
    logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q, pc_plus_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic            illegal_q;

    always_ff @(posedge clk) begin
        if (!rst || FlushE) begin
            reg_write_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            jump_q        <= 1'b0;
            branch_q      <= 1'b0;
            alu_src_q     <= 1'b0;
            result_src_q  <= 2'b00;
            alu_control_q <= 3'b000;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_q         <= '0;
            pc_q          <= '0;
            pc_plus_q     <= '0;
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            rd_q          <= 5'd0;
            illegal_q     <= 1'b0;
        end else begin
            reg_write_q   <= reg_write_d;
            mem_write_q   <= mem_write_d;
            jump_q        <= jump_d;
            branch_q      <= branch_d;
            alu_src_q     <= alu_src_d;
            result_src_q  <= result_src_d;
            alu_control_q <= alu_control_d;
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            imm_q         <= imm_d;
            pc_q          <= PC_D;
            pc_plus_q     <= PCPlusD;
            rs1_q         <= rs1;
            rs2_q         <= rs2;
            rd_q          <= rd;
            illegal_q     <= illegal_d;
        end
    end

    assign RegWriteE   = reg_write_q;
    assign MemWriteE   = mem_write_q;
    assign JumpE       = jump_q;
    assign BranchE     = branch_q;
    assign ALUSrcE     = alu_src_q;
    assign ResultSrcE  = result_src_q;
    assign ALUControlE = alu_control_q;
    assign RD1_E       = rd1_q;
    assign RD2_E       = rd2_q;
    assign ImmExt_E    = imm_q;
    assign PC_E        = pc_q;
    assign PCPlusE     = pc_plus_q;
    assign RS1_E       = rs1_q;
    assign RS2_E       = rs2_q;
    assign RD_E        = rd_q;
    assign IllegalE    = illegal_q;

endmodule

// File: tb/tb_decode_pipeline.sv
// tb/tb_decode_pipeline.sv - table-driven self-checking bench for decode_pipeline
module tb_decode_pipeline;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr_D, PC_D, PCPlusD, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, ImmExt_E, PC_E, PCPlusE;
    logic [4:0]  RS1_E, RS2_E, RD_E;

    always #5 clk = ~clk;

    decode_pipeline dut (
        .clk(clk), .rst(rst), .Instr_D(Instr_D), .PC_D(PC_D), .PCPlusD(PCPlusD),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExt_E(ImmExt_E), .PC_E(PC_E), .PCPlusE(PCPlusE),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .IllegalE(IllegalE)
    );

    // ctrl = {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0], Illegal}
    localparam logic [10:0] C_NOP  = 11'b0_0_0_0_0_00_000_0;
    localparam logic [10:0] C_ILL  = 11'b0_0_0_0_0_00_000_1;
    localparam logic [10:0] C_ADDI = 11'b1_0_0_0_1_00_000_0;
    localparam logic [10:0] C_ADD  = 11'b1_0_0_0_0_00_000_0;
    localparam logic [10:0] C_SUB  = 11'b1_0_0_0_0_00_001_0;
    localparam logic [10:0] C_SLTI = 11'b1_0_0_0_1_00_101_0;
    localparam logic [10:0] C_SW   = 11'b0_1_0_0_1_00_000_0;
    localparam logic [10:0] C_LW   = 11'b1_0_0_0_1_01_000_0;
    localparam logic [10:0] C_BEQ  = 11'b0_0_0_1_0_00_001_0;
    localparam logic [10:0] C_JAL  = 11'b1_0_1_0_0_10_000_0;

    typedef struct {
        logic [31:0] instr;
        logic        we;
        logic [4:0]  rdw;
        logic [31:0] resw;
        logic        flush;
        logic [10:0] ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [14:0] regs;   // {rs1, rs2, rd}
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic we, input logic [4:0] rdw,
                                input logic [31:0] resw, input logic flush, input logic [10:0] ctrl,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd);
        vec_t v;
        v.instr = instr; v.we = we; v.rdw = rdw; v.resw = resw; v.flush = flush;
        v.ctrl = ctrl; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.regs = {rs1, rs2, rd};
        return v;
    endfunction

    // Drive one vector, clock it through, compare the ID/EX bundle #1 after the edge.
    task automatic apply(input string tag, input vec_t v, input logic [31:0] pc, input logic rst_v);
        logic [31:0] exp_pc;
        Instr_D = v.instr; RegWriteW = v.we; RDW = v.rdw; ResultW = v.resw;
        FlushE = v.flush; PC_D = pc; PCPlusD = pc + 32'd1; rst = rst_v;
        @(posedge clk);
        #1;
        exp_pc = (v.flush || !rst_v) ? 32'd0 : pc;
        chk({tag, " ctrl"}, {21'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
                             ResultSrcE, ALUControlE, IllegalE}, {21'd0, v.ctrl});
        chk({tag, " rd1"},  RD1_E, v.rd1);
        chk({tag, " rd2"},  RD2_E, v.rd2);
        chk({tag, " imm"},  ImmExt_E, v.imm);
        chk({tag, " regidx"}, {17'd0, RS1_E, RS2_E, RD_E}, {17'd0, v.regs});
        chk({tag, " pc"},   PC_E, exp_pc);
        chk({tag, " pcplus"}, PCPlusE, (exp_pc == 32'd0) ? 32'd0 : pc + 32'd1);
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(mk(32'h00500093, 0, 0, 0,          0, C_ADDI, 0,          0,          32'd5,        0, 5, 1));   // addi x1,x0,5
        tbl.push_back(mk(32'h000101B3, 1, 2, 32'h1234,   0, C_ADD,  32'h1234,   0,          0,            2, 0, 3));   // add x3,x2,x0 bypass
        tbl.push_back(mk(32'h000001B3, 1, 0, 32'hFFFF,   0, C_ADD,  0,          0,          0,            0, 0, 3));   // x0 write ignored
        tbl.push_back(mk(32'h000101B3, 0, 0, 0,          0, C_ADD,  32'h1234,   0,          0,            2, 0, 3));   // x2 stored
        tbl.push_back(mk(32'hFE512E23, 0, 0, 0,          0, C_SW,   32'h1234,   0,          32'hFFFFFFFC, 2, 5, 28));  // sw x5,-4(x2)
        tbl.push_back(mk(32'hFFFFFFFF, 0, 0, 0,          0, C_ILL,  0,          0,          0,            31, 31, 31)); // bad opcode
        tbl.push_back(mk(32'h00000000, 0, 0, 0,          0, C_NOP,  0,          0,          0,            0, 0, 0));   // bubble
        tbl.push_back(mk(32'h00812303, 0, 0, 0,          0, C_LW,   32'h1234,   0,          32'd8,        2, 8, 6));   // lw x6,8(x2)
        tbl.push_back(mk(32'h402103B3, 0, 0, 0,          0, C_SUB,  32'h1234,   32'h1234,   0,            2, 2, 7));   // sub x7,x2,x2
        tbl.push_back(mk(32'hFE010CE3, 0, 0, 0,          0, C_BEQ,  32'h1234,   0,          32'hFFFFFFF8, 2, 0, 25));  // beq x2,x0,-8
        tbl.push_back(mk(32'hFE011CE3, 0, 0, 0,          0, C_ILL,  32'h1234,   0,          32'hFFFFFFF8, 2, 0, 25));  // bne unsupported
        tbl.push_back(mk(32'h010000EF, 0, 0, 0,          0, C_JAL,  0,          0,          32'd16,       0, 16, 1));  // jal x1,+16
        tbl.push_back(mk(32'hFFF12493, 0, 0, 0,          0, C_SLTI, 32'h1234,   0,          32'hFFFFFFFF, 2, 31, 9));  // slti x9,x2,-1
        tbl.push_back(mk(32'hC0000513, 0, 0, 0,          0, C_ADDI, 0,          0,          32'hFFFFFC00, 0, 0, 10));  // addi bit30 set, still add
        tbl.push_back(mk(32'h00000000, 1, 4, 32'd7,      0, C_NOP,  0,          0,          0,            0, 0, 0));   // load x4=7
        tbl.push_back(mk(32'h004202B3, 1, 6, 32'd9,      1, C_NOP,  0,          0,          0,            0, 0, 0));   // flush, x6=9 still written
        tbl.push_back(mk(32'h006202B3, 0, 0, 0,          0, C_ADD,  32'd7,      32'd9,      0,            4, 6, 5));   // add x5,x4,x6
        tbl.push_back(mk(32'h007202B3, 1, 7, 32'h55,     0, C_ADD,  32'd7,      32'h55,     0,            4, 7, 5));   // rs2 bypass

        Instr_D = 0; PC_D = 0; PCPlusD = 0; RegWriteW = 0; RDW = 0; ResultW = 0; FlushE = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctrl", {21'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
                           ResultSrcE, ALUControlE, IllegalE}, 32'd0);
        chk("reset data", RD1_E | RD2_E | ImmExt_E | PC_E | PCPlusE, 32'd0);
        chk("reset idx", {17'd0, RS1_E, RS2_E, RD_E}, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i], 32'h100 + 32'(i), 1'b1);
        end

        // Reset with a valid instruction and a pending write: everything clears.
        apply("rst_mid", mk(32'h007202B3, 1, 8, 32'hAA, 0, C_NOP, 0, 0, 0, 0, 0, 0), 32'h200, 1'b0);
        // Registers written before reset now read back as zero.
        apply("post_rst_x4", mk(32'h004202B3, 0, 0, 0, 0, C_ADD, 0, 0, 0, 4, 4, 5), 32'h201, 1'b1);
        apply("post_rst_x7", mk(32'h007202B3, 0, 0, 0, 0, C_ADD, 0, 0, 0, 4, 7, 5), 32'h202, 1'b1);
        // Write to x8 was blocked by reset.
        apply("post_rst_x8", mk(32'h008202B3, 0, 0, 0, 0, C_ADD, 0, 0, 0, 4, 8, 5), 32'h203, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
